regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised successor to the processor register file: NUM_REGS x DATA_WIDTH
//  storage, one write port and two combinational read ports. Adds three things:
//  - write-to-read bypass;
//  - a per-register pending-write scoreboard (busy bits);
//  - a pending-write counter.
//  It sits between decode/issue, which marks destinations busy, and writeback,
//  which writes and clears them. Issue logic stalls on busy_A/busy_B.
// PARAMETERS
//  DATA_WIDTH  32  width of each register and of the data ports
//  ADDR_WIDTH  5   register address width; NUM_REGS = 2**ADDR_WIDTH
//  ZERO_REG    1   1: reg 0 reads 0, ignores writes, never busy; 0: reg 0 is a normal register
//  BYPASS      1   1: same-cycle write data and clear are forwarded to the read ports
// PORTS
//  clock             in   1           rising-edge clock
//  ctrl_reset        in   1           asynchronous, active-high reset
//  ctrl_writeEnable  in   1           writeback strobe
//  ctrl_writeReg     in   ADDR_WIDTH  writeback destination
//  data_writeReg     in   DATA_WIDTH  writeback data
//  ctrl_readRegA     in   ADDR_WIDTH  read port A address
//  ctrl_readRegB     in   ADDR_WIDTH  read port B address
//  data_readRegA     out  DATA_WIDTH  read port A data (combinational)
//  data_readRegB     out  DATA_WIDTH  read port B data (combinational)
//  ctrl_issueEnable  in   1           issue strobe: mark ctrl_issueReg pending
//  ctrl_issueReg     in   ADDR_WIDTH  destination being issued
//  busy_A            out  1           register at ctrl_readRegA has a pending write
//  busy_B            out  1           register at ctrl_readRegB has a pending write
//  pending_count     out  ADDR_WIDTH+1  number of set busy bits
// BEHAVIOUR
//  Reset (ctrl_reset=1, async):
//  - all registers <= 0, all busy bits <= 0, pending_count <= 0;
//  - outputs reflect this immediately and hold until reset releases.
//  Write, at posedge when ctrl_writeEnable=1:
//  - reg[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0;
//  - with ZERO_REG=1, writes to reg 0 are dropped.
//  Issue, at posedge when ctrl_issueEnable=1:
//  - busy[ctrl_issueReg] <= 1;
//  - with ZERO_REG=1, issue to reg 0 is ignored.
//  Simultaneous write and issue:
//  - same register: data is written AND the busy bit ends at 1 (issue wins; the
//    new producer is pending);
//  - different registers: both take effect.
//  Reads are combinational, zero latency:
//  - data_readRegX = reg[ctrl_readRegX];
//  - ZERO_REG=1 and address 0 -> data 0, busy 0.
//  Bypass (BYPASS=1), when ctrl_writeEnable=1 and ctrl_writeReg==ctrl_readRegX
//  (and the address is not 0 when ZERO_REG=1):
//  - data_readRegX = data_writeReg;
//  - busy_X = 0.
//  - A same-cycle issue never affects that cycle's busy_X; it shows from the next cycle.
//  BYPASS=0: read data and busy come from stored state only, so a write is
//  visible the cycle after its edge.
//  busy_X: busy[ctrl_readRegX], modified by bypass as above.
//  pending_count: registered; after every edge it equals popcount(busy).
//  - +1 when a clear bit gets set;
//  - -1 when a set bit gets cleared;
//  - no change on re-issue of a busy reg, a write to a non-busy reg, or
//    issue+write to the same busy reg.
//  - One edge can net +1, -1 or 0 (e.g. issue r3 while writing busy r5 -> 0).
//  - Range is 0..NUM_REGS (NUM_REGS-1 with ZERO_REG=1), so it never overflows.
//  Reset mid-operation: clears everything; in-flight pending writes are forgotten.
//  Addresses are full-range; there are no illegal values.
// TESTING
//  1. Reset, then write r5=0xDEADBEEF, then read A=5 next cycle -> 0xDEADBEEF, busy_A=0.
//  2. BYPASS=1: write r7=0x12345678 while reading A=7, B=7 in the same cycle ->
//     both ports 0x12345678 that cycle.
//  3. Write r0=0xFFFFFFFF and issue r0 (ZERO_REG=1) -> read r0 = 0, busy 0, pending_count 0.
//  4. Issue r3, then r4, then r3 again -> pending_count 1, 2, 2.
//     Then write r3 -> busy_A(3)=0, pending_count=1.
//  5. Same edge: issue r9 and write r9=0x55 -> r9 reads 0x55, busy=1, pending_count +1.
//     Same edge: issue r10 and write busy r4 -> pending_count unchanged.
//  6. Fill busy bits and write registers, then assert ctrl_reset mid-cycle (async)
//     -> all reads 0, busy 0, pending_count 0 before the next edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a write-to-read bypass, per-register busy bits and a
// count of pending writes. Decode/issue marks destinations busy. Writeback
// writes a register and clears its busy bit. Issue stalls on busy_A/busy_B.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_issueEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
    output logic                  busy_A,
    output logic                  busy_B,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    logic write_ok;
    logic issue_ok;
    logic count_inc;
    logic count_dec;
    logic zero_a;
    logic zero_b;
    logic hit_a;
    logic hit_b;

    // Qualify the write and issue strobes and work out this edge's effect on the count.
    // NOTE: every signal written here gets a value on every path.
    // A combinational path that skips a signal makes the tool hold its old value, which infers a latch.
    always_comb begin
        write_ok  = ctrl_writeEnable && !(ZERO_REG && (ctrl_writeReg == '0));
        issue_ok  = ctrl_issueEnable && !(ZERO_REG && (ctrl_issueReg == '0));
        // Issuing a register that is already busy adds no new pending write.
        count_inc = issue_ok && !busy[ctrl_issueReg];
        // A write to a busy register retires its pending write.
        // If the same register is issued on that edge, a new producer takes its place and the count stays the same.
        count_dec = write_ok && busy[ctrl_writeReg]
                    && !(issue_ok && (ctrl_issueReg == ctrl_writeReg));
    end

    // Register storage: one write port, and the whole array is cleared on reset.
    // NOTE: resetting every entry forces the array into flops rather than a RAM macro.
    // This is deliberate: the reset must clear the register contents.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            // NOTE: sequential state uses non-blocking assignments only.
            // All flops then update from the same pre-edge values.
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Busy bits: writeback clears the bit and issue sets it. Issue wins when both name the same register.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy <= '0;
        end else begin
            if (write_ok) begin
                busy[ctrl_writeReg] <= 1'b0;
            end
            // NOTE: this assignment comes after the clear above.
            // When both target the same bit, the last non-blocking assignment decides, so issue wins.
            if (issue_ok) begin
                busy[ctrl_issueReg] <= 1'b1;
            end
        end
    end

    // Pending-write counter, kept equal to the number of set busy bits.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            pending_count <= '0;
        end else begin
            case ({count_inc, count_dec})
                2'b10:   pending_count <= pending_count + COUNT_ONE;
                2'b01:   pending_count <= pending_count - COUNT_ONE;
                default: pending_count <= pending_count;
            endcase
        end
    end

    // Read port A: stored value, overridden by the hardwired zero register or by a same-cycle write.
    always_comb begin
        zero_a        = ZERO_REG && (ctrl_readRegA == '0);
        hit_a         = BYPASS && write_ok && (ctrl_writeReg == ctrl_readRegA);
        data_readRegA = regs[ctrl_readRegA];
        busy_A        = busy[ctrl_readRegA];
        if (zero_a) begin
            data_readRegA = '0;
            busy_A        = 1'b0;
        end else if (hit_a) begin
            // The value being written is final, so the register is no longer pending for this reader.
            data_readRegA = data_writeReg;
            busy_A        = 1'b0;
        end
    end

    // Read port B: same behaviour as port A.
    always_comb begin
        zero_b        = ZERO_REG && (ctrl_readRegB == '0);
        hit_b         = BYPASS && write_ok && (ctrl_writeReg == ctrl_readRegB);
        data_readRegB = regs[ctrl_readRegB];
        busy_B        = busy[ctrl_readRegB];
        if (zero_b) begin
            data_readRegB = '0;
            busy_B        = 1'b0;
        end else if (hit_b) begin
            data_readRegB = data_writeReg;
            busy_B        = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard with the default parameters.
// The driver applies one vector per cycle and queues the outputs expected for that cycle.
// A monitor pops one entry at each falling edge and compares.
module tb_regfile_scoreboard;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;
    logic        busy_A;
    logic        busy_B;
    logic [5:0]  pending_count;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_REG  (1'b1),
        .BYPASS    (1'b1)
    ) dut (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .ctrl_readRegA   (ctrl_readRegA),
        .ctrl_readRegB   (ctrl_readRegB),
        .data_readRegA   (data_readRegA),
        .data_readRegB   (data_readRegB),
        .ctrl_issueEnable(ctrl_issueEnable),
        .ctrl_issueReg   (ctrl_issueReg),
        .busy_A          (busy_A),
        .busy_B          (busy_B),
        .pending_count   (pending_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue what the outputs must show before the next edge.
    // mid_reset asserts the asynchronous reset part-way through the cycle.
    task automatic step(input string name, input logic rst, input logic mid_reset,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ir,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic eba, input logic ebb, input logic [5:0] ecnt);
        exp_t e;
        @(posedge clock);
        #1;
        ctrl_reset       = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_issueEnable = ie;
        ctrl_issueReg    = ir;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        if (mid_reset) begin
            #2;
            ctrl_reset = 1'b1;
        end
        e.name = name;
        e.a    = ea;
        e.b    = eb;
        e.ba   = eba;
        e.bb   = ebb;
        e.cnt  = ecnt;
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".dataA"}, data_readRegA, e.a);
            check({e.name, ".dataB"}, data_readRegB, e.b);
            check({e.name, ".busyA"}, 32'(busy_A), 32'(e.ba));
            check({e.name, ".busyB"}, 32'(busy_B), 32'(e.bb));
            check({e.name, ".count"}, 32'(pending_count), 32'(e.cnt));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_issueEnable = 1'b0;
        ctrl_issueReg    = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = '0;

        //    name          rst mid we wr  wd            ie ir  ra  rb  expA          expB          bA bB cnt
        step("reset",       1, 0, 0, 0,  32'h0,        0, 0,  5,  7,  32'h0,        32'h0,        0, 0, 0);
        // Write r5, then read it back on the next cycle.
        step("t1_wr5",      0, 0, 1, 5,  32'hDEADBEEF, 0, 0,  1,  2,  32'h0,        32'h0,        0, 0, 0);
        step("t1_rd5",      0, 0, 0, 0,  32'h0,        0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0);
        // Same-cycle bypass on both ports.
        step("t2_byp7",     0, 0, 1, 7,  32'h12345678, 0, 0,  7,  7,  32'h12345678, 32'h12345678, 0, 0, 0);
        // r0 ignores writes and issues.
        step("t3_zero_wr",  0, 0, 1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,        32'h0,        0, 0, 0);
        step("t3_zero_rd",  0, 0, 0, 0,  32'h0,        0, 0,  0,  7,  32'h0,        32'h12345678, 0, 0, 0);
        // Issue r3, r4, then r3 again. Each issue shows from the following cycle.
        step("t4_iss3",     0, 0, 0, 0,  32'h0,        1, 3,  3,  4,  32'h0,        32'h0,        0, 0, 0);
        step("t4_iss4",     0, 0, 0, 0,  32'h0,        1, 4,  3,  4,  32'h0,        32'h0,        1, 0, 1);
        step("t4_iss3b",    0, 0, 0, 0,  32'h0,        1, 3,  3,  4,  32'h0,        32'h0,        1, 1, 2);
        step("t4_wr3",      0, 0, 1, 3,  32'h33,       0, 0,  3,  4,  32'h33,       32'h0,        0, 1, 2);
        step("t4_after",    0, 0, 0, 0,  32'h0,        0, 0,  3,  4,  32'h33,       32'h0,        0, 1, 1);
        // Issue and write r9 on the same edge: the data lands and r9 stays busy.
        step("t5_iw9",      0, 0, 1, 9,  32'h55,       1, 9,  9,  4,  32'h55,       32'h0,        0, 1, 1);
        step("t5_chk9",     0, 0, 0, 0,  32'h0,        0, 0,  9,  4,  32'h55,       32'h0,        1, 1, 2);
        // Issue r10 while writing busy r4: the count does not change.
        step("t5_i10w4",    0, 0, 1, 4,  32'h44,       1, 10, 10, 4,  32'h0,        32'h44,       0, 0, 2);
        step("t5_chk10",    0, 0, 0, 0,  32'h0,        0, 0,  10, 4,  32'h0,        32'h44,       1, 0, 2);
        // Top address, then a write and issue to different registers on the same edge.
        step("iss31",       0, 0, 0, 0,  32'h0,        1, 31, 31, 9,  32'h0,        32'h55,       0, 1, 2);
        step("w31_i3",      0, 0, 1, 31, 32'hFFFFFFFF, 1, 3,  31, 3,  32'hFFFFFFFF, 32'h33,       0, 0, 3);
        step("chk31",       0, 0, 0, 0,  32'h0,        0, 0,  31, 3,  32'hFFFFFFFF, 32'h33,       0, 1, 3);
        step("t6_pre",      0, 0, 0, 0,  32'h0,        0, 0,  9,  5,  32'h55,       32'hDEADBEEF, 1, 0, 3);
        // Asynchronous reset raised mid-cycle clears everything before the next edge.
        step("t6_rst",      0, 1, 0, 0,  32'h0,        0, 0,  9,  5,  32'h0,        32'h0,        0, 0, 0);
        step("t6_hold",     1, 0, 0, 0,  32'h0,        0, 0,  9,  31, 32'h0,        32'h0,        0, 0, 0);
        step("t6_post",     0, 0, 0, 0,  32'h0,        0, 0,  3,  10, 32'h0,        32'h0,        0, 0, 0);

        @(posedge clock);
        @(negedge clock);
        #1;
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
